drive_cmd_arbiter: RTL
======================

Name: drive_cmd_arbiter

Overview:
- Sequences the drive motors from decoded IR remote keys, with a proximity-sensor safety override, command timeout, and brake-before-direction-change.
- Sits between the IR receiver/proximity blocks and the motor controller, which takes the 8-bit one-hot `motor_cmd`.
- Also schedules telemetry bytes into the UART transmitter over a valid/ready handshake.

Parameters:
- CMD_TIMEOUT_CYCLES, 25_000_000: idle cycles in DRIVE with no refreshing key before an auto-brake (0.5 s at 50 MHz).
- BRAKE_CYCLES, 5_000_000: cycles the brake command is held (100 ms).
- PROX_STOP_LEVEL, 4: the obstacle flag sets when `prox_level` < this value.
- PROX_HYST, 2: the obstacle flag clears when `prox_level` >= PROX_STOP_LEVEL + PROX_HYST.
- TX_PERIOD_CYCLES, 500_000: periodic telemetry interval (10 ms).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- ir_valid  in  1  one-cycle pulse: new decoded IR key
- ir_key  in  12  key code, bits [27:16] of the IR decoder output
- prox_level  in  4  distance level, 0 = nearest, 15 = clear
- motor_cmd  out  8  one-hot drive command to the motor controller
- motor_stat  out  3  encoded drive state
- obstacle  out  1  registered obstacle flag
- tx_valid  out  1  telemetry byte available
- tx_ready  in  1  UART transmitter accepts the byte
- tx_byte  out  8  telemetry byte

Behaviour:
- Key map (all other codes ignored, with no state change):
  - 12'hD02 = FWD, `motor_cmd` 8'h02, `motor_stat` 001
  - 12'hB04 = LEFT, 8'h08, 010
  - 12'hA05 = BRAKE, 8'h10, 011
  - 12'h906 = RIGHT, 8'h20, 100
  - 12'h708 = BACK, 8'h80, 101
  - Idle is 8'h00, 000.
- Reset: state IDLE, pending = none, timers = 0. Outputs: `motor_cmd` 0, `motor_stat` 0, `obstacle` 0, `tx_valid` 0, `tx_byte` 0. Any in-flight frame is dropped.
- Latency: every output is registered. A key or obstacle change in cycle N takes effect on the outputs at N+1.
- `obstacle` flag: sets when `prox_level` < PROX_STOP_LEVEL; clears when `prox_level` >= PROX_STOP_LEVEL + PROX_HYST; otherwise holds.
- IDLE state:
  - A direction key moves to DRIVE(dir) and loads the timeout.
  - FWD while `obstacle` = 1 is refused; the block stays in IDLE.
  - BRAKE key moves to BRAKE with pending = none.
- DRIVE(dir) state:
  - The same key reloads the timeout counter.
  - A different direction key moves to BRAKE with pending = new dir.
  - BRAKE key moves to BRAKE with pending = none.
  - Timeout expiry moves to BRAKE with pending = none.
  - dir = FWD and `obstacle` = 1 moves to BRAKE with pending = none. This takes priority over any key in the same cycle.
- BRAKE state:
  - `motor_cmd` = 8'h10 for exactly BRAKE_CYCLES cycles.
  - A direction key overwrites pending (last wins); a BRAKE key clears pending.
  - On expiry: if pending is non-none and not (FWD with `obstacle`), move to DRIVE(pending); otherwise move to IDLE.
- Simultaneous events:
  - A valid key in the same cycle as timeout expiry: the key wins.
  - Reset overrides everything.
- Telemetry frame request:
  - Raised by a periodic tick every TX_PERIOD_CYCLES, or by any change of `motor_stat` or `obstacle`.
  - Requests coalesce into one pending flag.
- Telemetry transmit:
  - When no frame is outstanding, a request captures `tx_byte` = {`prox_level`[3:0], `motor_stat`[2:0], 1'b1} and asserts `tx_valid`.
  - `tx_byte` is held stable while `tx_valid` = 1 and `tx_ready` = 0.
  - The transfer completes on `tx_valid` && `tx_ready`. `tx_valid` drops the next cycle unless a request is pending, in which case a fresh byte is captured back-to-back.
  - Ticks during an outstanding frame set the pending flag only and are never queued deeper than one.
- Counters saturate/reload only as specified above; no wrap-around side effects.

Test Plan (CMD_TIMEOUT_CYCLES = 100, BRAKE_CYCLES = 10, TX_PERIOD_CYCLES = 50):
- Reset, then `ir_valid` with `ir_key` = 12'hD02, `prox_level` = 15 -> `motor_cmd` = 8'h02 and `motor_stat` = 001 one cycle later. No further key -> at 100 cycles `motor_cmd` = 8'h10 for 10 cycles, then 8'h00.
- In DRIVE FWD, send key 12'h708 -> 10 cycles of 8'h10, then 8'h80. Send 12'hB04 and then 12'h906 during the brake -> resumes with 8'h20.
- In DRIVE FWD, drop `prox_level` to 3 -> `obstacle` = 1 and brake. FWD key in IDLE is refused. `prox_level` = 5 leaves `obstacle` at 1; `prox_level` = 6 clears it.
- Key 12'h123 in any state -> no output change. Key on the same cycle as timeout expiry -> stays in DRIVE.
- Hold `tx_ready` = 0 for 200 cycles -> `tx_valid` = 1 with `tx_byte` constant. Release -> one transfer, then one back-to-back coalesced frame, with `tx_byte` bit0 = 1.
- Assert `rst` during BRAKE with `tx_valid` high -> all outputs 0 next cycle.

Source files
------------

// File: rtl/drive_cmd_arbiter.sv
// Drive-motor command arbiter: maps IR keys to one-hot motor commands with
// obstacle override, command timeout, brake-before-reverse and UART telemetry.
module drive_cmd_arbiter #(
  parameter int CMD_TIMEOUT_CYCLES = 25_000_000,
  parameter int BRAKE_CYCLES       = 5_000_000,
  parameter int PROX_STOP_LEVEL    = 4,
  parameter int PROX_HYST          = 2,
  parameter int TX_PERIOD_CYCLES   = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_valid,
  input  logic [11:0] ir_key,
  input  logic [3:0]  prox_level,
  output logic [7:0]  motor_cmd,
  output logic [2:0]  motor_stat,
  output logic        obstacle,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte
);

  typedef enum logic [1:0] {IDLE, DRIVE, BRAKE} state_t;

  localparam logic [2:0] STAT_NONE  = 3'd0;
  localparam logic [2:0] STAT_FWD   = 3'd1;
  localparam logic [2:0] STAT_LEFT  = 3'd2;
  localparam logic [2:0] STAT_BRAKE = 3'd3;
  localparam logic [2:0] STAT_RIGHT = 3'd4;
  localparam logic [2:0] STAT_BACK  = 3'd5;

  localparam int TMAX = (CMD_TIMEOUT_CYCLES > BRAKE_CYCLES) ? CMD_TIMEOUT_CYCLES : BRAKE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(TX_PERIOD_CYCLES + 1);
  localparam logic [TW-1:0] CMD_LOAD   = TW'(CMD_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] BRAKE_LOAD = TW'(BRAKE_CYCLES - 1);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TX_PERIOD_CYCLES - 1);

  state_t        state_q, state_d;
  logic [2:0]    dir_q, dir_d;
  logic [2:0]    pend_q, pend_d;
  logic [2:0]    pendNext;
  logic [TW-1:0] timer_q, timer_d;
  logic          timerZero;
  logic          obstacle_q, obstacle_d;
  logic [7:0]    motorCmd_q, motorCmd_d;
  logic [2:0]    motorStat_q, motorStat_d;
  logic [PW-1:0] tickCnt_q, tickCnt_d;
  logic          tick;
  logic          reqEvent;
  logic          txPend_q, txPend_d;
  logic          txValid_q, txValid_d;
  logic [7:0]    txByte_q, txByte_d;
  logic          capture;
  logic [2:0]    keyCode;
  logic          keyDir, keyBrake;

  always_comb begin
    keyCode = STAT_NONE;
    if (ir_valid) begin
      case (ir_key)
        12'hD02: keyCode = STAT_FWD;
        12'hB04: keyCode = STAT_LEFT;
        12'hA05: keyCode = STAT_BRAKE;
        12'h906: keyCode = STAT_RIGHT;
        12'h708: keyCode = STAT_BACK;
        default: keyCode = STAT_NONE;
      endcase
    end
  end

  assign keyBrake  = (keyCode == STAT_BRAKE);
  assign keyDir    = (keyCode != STAT_NONE) && !keyBrake;
  assign timerZero = (timer_q == '0);

  // Hysteresis band between the stop and clear levels holds the flag.
  always_comb begin
    obstacle_d = obstacle_q;
    if (int'(prox_level) < PROX_STOP_LEVEL)
      obstacle_d = 1'b1;
    else if (int'(prox_level) >= PROX_STOP_LEVEL + PROX_HYST)
      obstacle_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    pendNext = pend_q;
    timer_d  = timerZero ? timer_q : timer_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (keyBrake) begin
          state_d = BRAKE;
          pend_d  = STAT_NONE;
          timer_d = BRAKE_LOAD;
        end else if (keyDir && !(keyCode == STAT_FWD && obstacle_q)) begin
          state_d = DRIVE;
          dir_d   = keyCode;
          timer_d = CMD_LOAD;
        end
      end
      DRIVE: begin
        // Obstacle ahead beats any key; a key beats a coincident timeout.
        if (dir_q == STAT_FWD && obstacle_q) begin
          state_d = BRAKE;
          pend_d  = STAT_NONE;
          timer_d = BRAKE_LOAD;
        end else if (keyBrake) begin
          state_d = BRAKE;
          pend_d  = STAT_NONE;
          timer_d = BRAKE_LOAD;
        end else if (keyDir && keyCode != dir_q) begin
          state_d = BRAKE;
          pend_d  = keyCode;
          timer_d = BRAKE_LOAD;
        end else if (keyDir) begin
          timer_d = CMD_LOAD;
        end else if (timerZero) begin
          state_d = BRAKE;
          pend_d  = STAT_NONE;
          timer_d = BRAKE_LOAD;
        end
      end
      BRAKE: begin
        if (keyBrake)
          pendNext = STAT_NONE;
        else if (keyDir)
          pendNext = keyCode;
        pend_d = pendNext;
        if (timerZero) begin
          pend_d = STAT_NONE;
          if (pendNext != STAT_NONE && !(pendNext == STAT_FWD && obstacle_q)) begin
            state_d = DRIVE;
            dir_d   = pendNext;
            timer_d = CMD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    motorStat_d = STAT_NONE;
    case (state_d)
      DRIVE:   motorStat_d = dir_d;
      BRAKE:   motorStat_d = STAT_BRAKE;
      default: motorStat_d = STAT_NONE;
    endcase
    case (motorStat_d)
      STAT_FWD:   motorCmd_d = 8'h02;
      STAT_LEFT:  motorCmd_d = 8'h08;
      STAT_BRAKE: motorCmd_d = 8'h10;
      STAT_RIGHT: motorCmd_d = 8'h20;
      STAT_BACK:  motorCmd_d = 8'h80;
      default:    motorCmd_d = 8'h00;
    endcase
  end

  // Periodic ticks and status changes coalesce into a single pending request.
  always_comb begin
    tick      = (tickCnt_q == TICK_LAST);
    tickCnt_d = tick ? '0 : tickCnt_q + 1'b1;
    reqEvent  = tick || (motorStat_d != motorStat_q) || (obstacle_d != obstacle_q);
    txValid_d = txValid_q;
    txByte_d  = txByte_q;
    capture   = 1'b0;
    if (!txValid_q || tx_ready) begin
      if (txPend_q) begin
        capture   = 1'b1;
        txValid_d = 1'b1;
        txByte_d  = {prox_level, motorStat_q, 1'b1};
      end else begin
        txValid_d = 1'b0;
      end
    end
    txPend_d = (txPend_q && !capture) || reqEvent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dir_q       <= STAT_NONE;
      pend_q      <= STAT_NONE;
      timer_q     <= '0;
      obstacle_q  <= 1'b0;
      motorCmd_q  <= 8'h00;
      motorStat_q <= STAT_NONE;
      tickCnt_q   <= '0;
      txPend_q    <= 1'b0;
      txValid_q   <= 1'b0;
      txByte_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      pend_q      <= pend_d;
      timer_q     <= timer_d;
      obstacle_q  <= obstacle_d;
      motorCmd_q  <= motorCmd_d;
      motorStat_q <= motorStat_d;
      tickCnt_q   <= tickCnt_d;
      txPend_q    <= txPend_d;
      txValid_q   <= txValid_d;
      txByte_q    <= txByte_d;
    end
  end

  assign motor_cmd  = motorCmd_q;
  assign motor_stat = motorStat_q;
  assign obstacle   = obstacle_q;
  assign tx_valid   = txValid_q;
  assign tx_byte    = txByte_q;

endmodule
